// File: rtl/alu_mdu_ctrl_if.sv
// Request/response bundle between the EX-stage controller and the ALU/MDU.
// The controller (master) drives the request fields; the ALU/MDU (slave)
// returns the registered result, the HI/LO registers and the handshake flags.
interface alu_mdu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       aluop;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             illegal;

    modport master (
        output start, aluop, funct, a, b,
        input  result, zero, hi, lo, busy, done, illegal
    );

    modport slave (
        input  start, aluop, funct, a, b,
        output result, zero, hi, lo, busy, done, illegal
    );
endinterface

// File: rtl/alu_mdu_ctrl.sv
// ALU decoder plus iterative multiply/divide unit for the multicycle EX stage.
// Single-cycle ops complete on the accept edge; MULT/MULTU/DIV/DIVU run a
// WIDTH-step shift-add / restoring shift-subtract loop over magnitudes and
// apply sign correction in a final FIX cycle before writing HI/LO.
module alu_mdu_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_mdu_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_e;
    typedef enum logic [1:0] {K_ALU, K_ILL, K_MUL, K_DIV} kind_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic             busy_q, done_q, illegal_q;

    // Iteration datapath: acc_hi/acc_lo hold {partial product, multiplier}
    // for MUL and {remainder, quotient/dividend} for DIV; opnd is the
    // multiplicand or divisor magnitude.
    logic [WIDTH-1:0] opnd, acc_hi, acc_lo;
    logic             is_div, neg_q, neg_r;

    kind_e            kind;
    logic [WIDTH-1:0] alu_res, hi_nxt, lo_nxt;
    logic             wr_hi, wr_lo, op_signed;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic [WIDTH:0]   mul_add, div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff, step_hi, step_lo;

    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    // Decode the request and compute every single-cycle result.
    always_comb begin
        // NOTE: every output of a combinational block gets a default up front;
        // a path that leaves one unassigned would infer a latch.
        kind      = K_ILL;
        alu_res   = '0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        op_signed = 1'b0;
        case (bus.aluop)
            2'b00: begin kind = K_ALU; alu_res = bus.a + bus.b; end
            2'b01: begin kind = K_ALU; alu_res = bus.a - bus.b; end
            2'b10: begin
                case (bus.funct)
                    6'b100000, 6'b100001: begin kind = K_ALU; alu_res = bus.a + bus.b; end
                    6'b100010, 6'b100011: begin kind = K_ALU; alu_res = bus.a - bus.b; end
                    6'b100100: begin kind = K_ALU; alu_res = bus.a & bus.b; end
                    6'b100101: begin kind = K_ALU; alu_res = bus.a | bus.b; end
                    6'b100110: begin kind = K_ALU; alu_res = bus.a ^ bus.b; end
                    6'b100111: begin kind = K_ALU; alu_res = ~(bus.a | bus.b); end
                    6'b101010: begin kind = K_ALU; alu_res = WIDTH'($signed(bus.a) < $signed(bus.b)); end
                    6'b101011: begin kind = K_ALU; alu_res = WIDTH'(bus.a < bus.b); end
                    6'b010000: begin kind = K_ALU; alu_res = hi_q; end
                    6'b010010: begin kind = K_ALU; alu_res = lo_q; end
                    6'b010001: begin kind = K_ALU; alu_res = bus.a; wr_hi = 1'b1; hi_nxt = bus.a; end
                    6'b010011: begin kind = K_ALU; alu_res = bus.a; wr_lo = 1'b1; lo_nxt = bus.a; end
                    6'b011000: begin kind = K_MUL; op_signed = 1'b1; end
                    6'b011001: begin kind = K_MUL; end
                    6'b011010, 6'b011011: begin
                        op_signed = ~bus.funct[0];
                        if (bus.b == '0) begin
                            // Divide by zero finishes at once: quotient all ones, remainder = dividend.
                            kind    = K_ALU;
                            alu_res = '1;
                            wr_hi   = 1'b1;
                            wr_lo   = 1'b1;
                            hi_nxt  = bus.a;
                            lo_nxt  = '1;
                        end else begin
                            kind = K_DIV;
                        end
                    end
                    default: kind = K_ILL;
                endcase
            end
            default: kind = K_ILL;
        endcase
    end

    // Operand magnitudes and signs for the iterative ops.
    always_comb begin
        sign_a = op_signed & bus.a[WIDTH-1];
        sign_b = op_signed & bus.b[WIDTH-1];
        mag_a  = sign_a ? -bus.a : bus.a;
        mag_b  = sign_b ? -bus.b : bus.b;
    end

    // One multiply (shift-add) or divide (restoring shift-subtract) step.
    always_comb begin
        mul_add   = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd}) : {1'b0, acc_hi};
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        // When div_ge holds the difference is below the divisor, so WIDTH bits suffice.
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        if (is_div) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_add[WIDTH:1];
            step_lo = {mul_add[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction applied in FIX: product and quotient take sign(a)^sign(b),
    // the remainder takes the dividend's sign.
    always_comb begin
        prod_raw = {acc_hi, acc_lo};
        prod_fix = neg_q ? -prod_raw : prod_raw;
        if (is_div) begin
            fix_lo = neg_q ? -acc_lo : acc_lo;
            fix_hi = neg_r ? -acc_hi : acc_hi;
        end else begin
            {fix_hi, fix_lo} = prod_fix;
        end
    end

    // Control FSM with registered result, HI/LO and handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            result_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            opnd      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            is_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (kind)
                            K_ALU: begin
                                result_q <= alu_res;
                                done_q   <= 1'b1;
                                if (wr_hi) hi_q <= hi_nxt;
                                if (wr_lo) lo_q <= lo_nxt;
                            end
                            K_ILL: begin
                                result_q  <= '0;
                                done_q    <= 1'b1;
                                illegal_q <= 1'b1;
                            end
                            K_MUL: begin
                                opnd   <= mag_a;
                                acc_hi <= '0;
                                acc_lo <= mag_b;
                                is_div <= 1'b0;
                                neg_q  <= sign_a ^ sign_b;
                                neg_r  <= 1'b0;
                                cnt    <= '0;
                                busy_q <= 1'b1;
                                state  <= ITER;
                            end
                            default: begin
                                opnd   <= mag_b;
                                acc_hi <= '0;
                                acc_lo <= mag_a;
                                is_div <= 1'b1;
                                neg_q  <= sign_a ^ sign_b;
                                neg_r  <= sign_a;
                                cnt    <= '0;
                                busy_q <= 1'b1;
                                state  <= ITER;
                            end
                        endcase
                    end
                end
                ITER: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    hi_q     <= fix_hi;
                    lo_q     <= fix_lo;
                    result_q <= fix_lo;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result  = result_q;
    assign bus.zero    = (result_q == '0);
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Testbench for alu_mdu_ctrl (WIDTH=32): fixed vector table, hand sequences
// for the multi-cycle corners, then random ops against an arithmetic model.
module tb_alu_mdu_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    alu_mdu_ctrl_if #(.WIDTH(W)) bus ();

    alu_mdu_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ill;
        int          lat;
    } exp_t;

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] res, hi, lo, input logic ill, input int lat);
        exp_t e;
        e.res = res; e.hi = hi; e.lo = lo; e.ill = ill; e.lat = lat;
        return e;
    endfunction

    // Reference: plain 64-bit arithmetic, SV signed '/' and '%' truncate toward zero.
    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                   input logic [31:0] a, b, hi, lo);
        exp_t e;
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] p;
        e = mk(32'h0, hi, lo, 1'b0, 1);
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (op == 2'b00) e.res = a + b;
        else if (op == 2'b01) e.res = a - b;
        else if (op == 2'b11) e.ill = 1'b1;
        else begin
            case (f)
                6'h20, 6'h21: e.res = a + b;
                6'h22, 6'h23: e.res = a - b;
                6'h24: e.res = a & b;
                6'h25: e.res = a | b;
                6'h26: e.res = a ^ b;
                6'h27: e.res = ~(a | b);
                6'h2a: e.res = (sa < sb) ? 32'd1 : 32'd0;
                6'h2b: e.res = (a < b) ? 32'd1 : 32'd0;
                6'h10: e.res = hi;
                6'h12: e.res = lo;
                6'h11: begin e.hi = a; e.res = a; end
                6'h13: begin e.lo = a; e.res = a; end
                6'h18, 6'h19: begin
                    if (f == 6'h18) p = sa * sb;
                    else p = {32'h0, a} * {32'h0, b};
                    e.hi = p[63:32]; e.lo = p[31:0]; e.res = p[31:0]; e.lat = W + 2;
                end
                6'h1a, 6'h1b: begin
                    if (b == 32'h0) begin
                        e.lo = 32'hFFFFFFFF; e.hi = a; e.res = 32'hFFFFFFFF;
                    end else begin
                        if (f == 6'h1a) begin
                            sq = sa / sb; sr = sa % sb;
                            e.lo = sq[31:0]; e.hi = sr[31:0];
                        end else begin
                            e.lo = a / b; e.hi = a % b;
                        end
                        e.res = e.lo; e.lat = W + 2;
                    end
                end
                default: e.ill = 1'b1;
            endcase
        end
        return e;
    endfunction

    // Issue one op starting at a negedge; returns at a negedge one cycle after done.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, b, input bit glitch, input exp_t e);
        int cyc;
        int busy_cyc;
        bus.start = 1'b1; bus.aluop = op; bus.funct = f; bus.a = a; bus.b = b;
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        busy_cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (bus.busy === 1'b1) busy_cyc++;
            bus.start = (glitch && bus.busy === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.aluop = 2'($urandom_range(0, 3));
            bus.a = $urandom;
            bus.b = $urandom;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check({tag, ".lat"}, 32'(cyc), 32'(e.lat));
        check({tag, ".busy_cycles"}, 32'(busy_cyc), (e.lat == 1) ? 32'd0 : 32'(W + 1));
        check({tag, ".result"}, bus.result, e.res);
        check({tag, ".zero"}, 32'(bus.zero), 32'(e.res == 32'h0));
        check({tag, ".hi"}, bus.hi, e.hi);
        check({tag, ".lo"}, bus.lo, e.lo);
        check({tag, ".illegal"}, 32'(bus.illegal), 32'(e.ill));
        check({tag, ".busy_at_done"}, 32'(bus.busy), 32'h0);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(bus.done), 32'h0);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".result"}, bus.result, 32'h0);
        check({tag, ".hi"}, bus.hi, 32'h0);
        check({tag, ".lo"}, bus.lo, 32'h0);
        check({tag, ".busy"}, 32'(bus.busy), 32'h0);
        check({tag, ".done"}, 32'(bus.done), 32'h0);
        check({tag, ".illegal"}, 32'(bus.illegal), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        logic [5:0] fl[18];
        exp_t e;

        vecs[0]  = '{2'b00, 6'h3f, 32'd5,         32'd3,         32'd8,         1'b0};
        vecs[1]  = '{2'b01, 6'h00, 32'd5,         32'd7,         32'hFFFFFFFE,  1'b0};
        vecs[2]  = '{2'b10, 6'h21, 32'hFFFFFFFF,  32'd1,         32'h0,         1'b0};
        vecs[3]  = '{2'b10, 6'h24, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  1'b0};
        vecs[4]  = '{2'b10, 6'h25, 32'hF0F0F0F0,  32'hFF00FF00,  32'hFFF0FFF0,  1'b0};
        vecs[5]  = '{2'b10, 6'h26, 32'hF0F0F0F0,  32'hFF00FF00,  32'h0FF00FF0,  1'b0};
        vecs[6]  = '{2'b10, 6'h27, 32'hF0F0F0F0,  32'hFF00FF00,  32'h000F000F,  1'b0};
        vecs[7]  = '{2'b10, 6'h2a, 32'hFFFFFFFE,  32'd1,         32'd1,         1'b0};
        vecs[8]  = '{2'b10, 6'h2b, 32'hFFFFFFFE,  32'd1,         32'd0,         1'b0};
        vecs[9]  = '{2'b10, 6'h22, 32'd0,         32'd1,         32'hFFFFFFFF,  1'b0};
        vecs[10] = '{2'b11, 6'h20, 32'd9,         32'd9,         32'h0,         1'b1};
        vecs[11] = '{2'b10, 6'h3f, 32'd9,         32'd9,         32'h0,         1'b1};
        vecs[12] = '{2'b10, 6'h23, 32'd10,        32'd10,        32'h0,         1'b0};

        fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
               6'h2b, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b};

        reset_n = 1'b0;
        bus.start = 1'b0; bus.aluop = 2'b00; bus.funct = 6'h0; bus.a = '0; bus.b = '0;
        #12;
        check_all_zero("reset");
        check("reset.zero", 32'(bus.zero), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Fixed vector table: single-cycle ops, HI/LO untouched.
        for (int i = 0; i < 13; i++) begin
            e = mk(vecs[i].res, m_hi, m_lo, vecs[i].ill, 1);
            do_op($sformatf("vec%0d", i), vecs[i].aluop, vecs[i].funct, vecs[i].a, vecs[i].b, 1'b0, e);
        end

        // Multi-cycle corners.
        do_op("mult_neg", 2'b10, 6'h18, 32'hFFFFFFFD, 32'd5, 1'b0,
              mk(32'hFFFFFFF1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34));
        do_op("multu_glitch", 2'b10, 6'h19, 32'hFFFFFFFF, 32'd2, 1'b1,
              mk(32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE, 1'b0, 34));
        do_op("div_neg", 2'b10, 6'h1a, 32'd7, 32'hFFFFFFFE, 1'b0,
              mk(32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34));
        do_op("div_min_by_m1", 2'b10, 6'h1a, 32'h80000000, 32'hFFFFFFFF, 1'b0,
              mk(32'h80000000, 32'h0, 32'h80000000, 1'b0, 34));
        do_op("divu_by_zero", 2'b10, 6'h1b, 32'h1234, 32'h0, 1'b0,
              mk(32'hFFFFFFFF, 32'h1234, 32'hFFFFFFFF, 1'b0, 1));
        do_op("reserved_op", 2'b11, 6'h18, 32'd3, 32'd4, 1'b0,
              mk(32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1, 1));
        do_op("mthi", 2'b10, 6'h11, 32'hCAFE0001, 32'd0, 1'b0,
              mk(32'hCAFE0001, 32'hCAFE0001, 32'hFFFFFFFF, 1'b0, 1));
        do_op("mtlo", 2'b10, 6'h13, 32'h0BAD0002, 32'd0, 1'b0,
              mk(32'h0BAD0002, 32'hCAFE0001, 32'h0BAD0002, 1'b0, 1));
        do_op("mfhi", 2'b10, 6'h10, 32'd0, 32'd0, 1'b0,
              mk(32'hCAFE0001, 32'hCAFE0001, 32'h0BAD0002, 1'b0, 1));
        do_op("mflo", 2'b10, 6'h12, 32'd0, 32'd0, 1'b0,
              mk(32'h0BAD0002, 32'hCAFE0001, 32'h0BAD0002, 1'b0, 1));

        // Back-to-back: start held high in the done cycle is accepted.
        bus.start = 1'b1; bus.aluop = 2'b00; bus.a = 32'd2; bus.b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        check("b2b.first_done", 32'(bus.done), 32'h1);
        check("b2b.first_result", bus.result, 32'd5);
        bus.aluop = 2'b01; bus.a = 32'd10; bus.b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        check("b2b.second_done", 32'(bus.done), 32'h1);
        check("b2b.second_result", bus.result, 32'd6);
        bus.start = 1'b0;
        @(negedge clk);
        check("b2b.idle_done", 32'(bus.done), 32'h0);

        // Asynchronous reset in the middle of a DIV.
        bus.start = 1'b1; bus.aluop = 2'b10; bus.funct = 6'h1a; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("rst_mid.busy_before", 32'(bus.busy), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        reset_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        do_op("post_reset_add", 2'b00, 6'h0, 32'd40, 32'd2, 1'b0, mk(32'd42, 32'h0, 32'h0, 1'b0, 1));
        do_op("post_reset_mfhi", 2'b10, 6'h10, 32'd0, 32'd0, 1'b0, mk(32'h0, 32'h0, 32'h0, 1'b0, 1));

        // Random ops against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  op;
            logic [5:0]  f;
            logic [31:0] a, b;
            int sel;
            sel = $urandom_range(0, 15);
            if (sel == 0) op = 2'b00;
            else if (sel == 1) op = 2'b01;
            else if (sel == 2) op = 2'b11;
            else op = 2'b10;
            f = (sel == 3) ? 6'($urandom) : fl[$urandom_range(0, 17)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 40)) - 32'd20; end
                default: ;
            endcase
            e = model(op, f, a, b, m_hi, m_lo);
            do_op($sformatf("rnd%0d", i), op, f, a, b, 1'($urandom_range(0, 1)), e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
